// File: rtl/occupancy_pkg.sv
// occupancy_pkg: lane FSM state type and debounced {A,B} sensor patterns
package occupancy_pkg;
  typedef enum logic [2:0] {IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A, FAULT} lane_state_t;
  localparam logic [1:0] PAT_NONE = 2'b00;
  localparam logic [1:0] PAT_A    = 2'b10;
  localparam logic [1:0] PAT_B    = 2'b01;
  localparam logic [1:0] PAT_AB   = 2'b11;
endpackage

// File: rtl/lane_dir_fsm.sv
// lane_dir_fsm: synchronise, debounce and decode one lane's beam pair into entry/exit/fault pulses
module lane_dir_fsm
  import occupancy_pkg::*;
#(
  parameter int DEBOUNCE = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_a,
  input  logic sensor_b,
  output logic entered,
  output logic exited,
  output logic fault
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  logic [1:0] s1, s2;
  logic deb [2];
  logic [CW-1:0] cnt [2];
  logic [1:0] pat;
  lane_state_t state, state_nx;
  logic ent_nx, ext_nx, flt_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {sensor_a, sensor_b};
      s2 <= s1;
    end
  for (genvar i = 0; i < 2; i++) begin : g_deb
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        cnt[i] <= '0;
        deb[i] <= 1'b0;
      end else if (s2[i] == deb[i]) begin
        cnt[i] <= '0;
      end else if (cnt[i] == CW'(DEBOUNCE - 1)) begin
        deb[i] <= s2[i];
        cnt[i] <= '0;
      end else begin
        cnt[i] <= cnt[i] + 1'b1;
      end
  end
  assign pat = {deb[1], deb[0]};
  // Each state: own pattern holds, previous pattern steps back, next pattern advances, anything else faults
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = pat == PAT_A ? IN_A : pat == PAT_B ? OUT_B : pat == PAT_AB ? FAULT : IDLE;
      IN_A:    state_nx = pat == PAT_NONE ? IDLE : pat == PAT_AB ? IN_AB : pat == PAT_B ? FAULT : IN_A;
      IN_AB:   state_nx = pat == PAT_A ? IN_A : pat == PAT_B ? IN_B : pat == PAT_NONE ? FAULT : IN_AB;
      IN_B:    state_nx = pat == PAT_AB ? IN_AB : pat == PAT_NONE ? IDLE : pat == PAT_A ? FAULT : IN_B;
      OUT_B:   state_nx = pat == PAT_NONE ? IDLE : pat == PAT_AB ? OUT_AB : pat == PAT_A ? FAULT : OUT_B;
      OUT_AB:  state_nx = pat == PAT_B ? OUT_B : pat == PAT_A ? OUT_A : pat == PAT_NONE ? FAULT : OUT_AB;
      OUT_A:   state_nx = pat == PAT_AB ? OUT_AB : pat == PAT_NONE ? IDLE : pat == PAT_B ? FAULT : OUT_A;
      FAULT:   state_nx = pat == PAT_NONE ? IDLE : FAULT;
      default: state_nx = IDLE;
    endcase
    ent_nx = state == IN_B && pat == PAT_NONE;
    ext_nx = state == OUT_A && pat == PAT_NONE;
    flt_nx = state != FAULT && state_nx == FAULT;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= IDLE;
      entered <= 1'b0;
      exited  <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state   <= state_nx;
      entered <= ent_nx;
      exited  <= ext_nx;
      fault   <= flt_nx;
    end
endmodule

// File: rtl/occupancy_tracker.sv
// occupancy_tracker: multi-lane entry/exit tracker with saturating shared occupancy counter
module occupancy_tracker
  import occupancy_pkg::*;
#(
  parameter int N_LANES  = 2,
  parameter int CNT_W    = 8,
  parameter int CAPACITY = 200,
  parameter int DEBOUNCE = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_LANES-1:0] sensor_a,
  input  logic [N_LANES-1:0] sensor_b,
  input  logic               clear,
  output logic [N_LANES-1:0] entered,
  output logic [N_LANES-1:0] exited,
  output logic [N_LANES-1:0] lane_fault,
  output logic [CNT_W-1:0]   occupancy,
  output logic               full,
  output logic               empty,
  output logic               overflow_err,
  output logic               underflow_err
);
  localparam logic signed [CNT_W+1:0] CAP_S = (CNT_W + 2)'(CAPACITY);
  logic signed [CNT_W+1:0] nxt;
  logic over, under;
  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    lane_dir_fsm #(.DEBOUNCE(DEBOUNCE)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .sensor_a (sensor_a[g]),
      .sensor_b (sensor_b[g]),
      .entered  (entered[g]),
      .exited   (exited[g]),
      .fault    (lane_fault[g])
    );
  end
  // Two extra bits give headroom for the sign and for summing every lane in one cycle
  always_comb begin
    nxt = {2'b00, occupancy};
    for (int i = 0; i < N_LANES; i++)
      nxt = nxt + (CNT_W + 2)'(entered[i]) - (CNT_W + 2)'(exited[i]);
    under = nxt[CNT_W+1];
    over  = !under && nxt > CAP_S;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      occupancy     <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (clear) begin
      occupancy     <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      occupancy     <= under ? '0 : over ? CAP_S[CNT_W-1:0] : nxt[CNT_W-1:0];
      overflow_err  <= overflow_err | over;
      underflow_err <= underflow_err | under;
    end
  assign full  = occupancy == CAP_S[CNT_W-1:0];
  assign empty = occupancy == '0;
endmodule
